// File: rtl/wb_crossbar_rr.sv
// Round-robin N-master to M-slave Wishbone classic shared-bus interconnect with registered grant.
// Optional owner watchdog (err pulse on a stalled strobe) is built when WB_CROSSBAR_TIMEOUT_EN is defined.
module wb_crossbar_rr #(
   parameter int unsigned ADDR_WIDTH   = 24,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned SEL_WIDTH    = DATA_WIDTH / 8,
   parameter int unsigned MASTER_COUNT = 3,
   parameter int unsigned SLAVE_BITS   = 2,
   parameter int unsigned TIMEOUT      = 15
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [MASTER_COUNT-1:0]              wbm_cyc_i,
   input  logic [MASTER_COUNT-1:0]              wbm_stb_i,
   input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [MASTER_COUNT-1:0]              wbm_we_i,
   input  logic [MASTER_COUNT*SEL_WIDTH-1:0]    wbm_sel_i,
   input  logic [MASTER_COUNT*DATA_WIDTH-1:0]   wbm_dat_i,
   output logic [MASTER_COUNT-1:0]              wbm_ack_o,
   output logic [MASTER_COUNT-1:0]              wbm_err_o,
   output logic [MASTER_COUNT-1:0]              wbm_rty_o,
   output logic [DATA_WIDTH-1:0]                wbm_dat_o,
   output logic [(1<<SLAVE_BITS)-1:0]           wbs_cyc_o,
   output logic [(1<<SLAVE_BITS)-1:0]           wbs_stb_o,
   output logic [ADDR_WIDTH-SLAVE_BITS-1:0]     wbs_adr_o,
   output logic                                 wbs_we_o,
   output logic [SEL_WIDTH-1:0]                 wbs_sel_o,
   output logic [DATA_WIDTH-1:0]                wbs_dat_o,
   input  logic [(1<<SLAVE_BITS)-1:0]           wbs_ack_i,
   input  logic [(1<<SLAVE_BITS)-1:0]           wbs_err_i,
   input  logic [(1<<SLAVE_BITS)-1:0]           wbs_rty_i,
   input  logic [(1<<SLAVE_BITS)*DATA_WIDTH-1:0] wbs_dat_i
);
   localparam int unsigned SLAVE_COUNT = 1 << SLAVE_BITS;
   localparam int unsigned GW = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        gnt_q, gnt_d, last_q, last_d;
   logic                 owned, own_cyc, own_stb, own_we;
   logic [ADDR_WIDTH-1:0] own_adr;
   logic [SEL_WIDTH-1:0]  own_sel;
   logic [DATA_WIDTH-1:0] own_dat, rsp_dat;
   logic [SLAVE_BITS-1:0] dec;
   logic                 rsp_ack, rsp_err, rsp_rty, tmo;
   logic                 found;

   assign owned = (state_q == OWNED);

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_sel = '0;
      own_dat = '0;
      for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
         if (gnt_q == GW'(k)) begin
            own_cyc = wbm_cyc_i[k];
            own_stb = wbm_stb_i[k];
            own_we  = wbm_we_i[k];
            own_adr = wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            own_sel = wbm_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            own_dat = wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign dec       = own_adr[ADDR_WIDTH-1 -: SLAVE_BITS];
   assign wbs_adr_o = own_adr[ADDR_WIDTH-SLAVE_BITS-1:0];
   assign wbs_we_o  = own_we;
   assign wbs_sel_o = own_sel;
   assign wbs_dat_o = own_dat;
   assign wbm_dat_o = rsp_dat;

   // Only the decoded slave may answer; anything else on the response lines is dropped here.
   always_comb begin
      rsp_ack = 1'b0;
      rsp_err = 1'b0;
      rsp_rty = 1'b0;
      rsp_dat = '0;
      for (int unsigned s = 0; s < SLAVE_COUNT; s++) begin
         if (dec == SLAVE_BITS'(s)) begin
            rsp_ack = wbs_ack_i[s];
            rsp_err = wbs_err_i[s];
            rsp_rty = wbs_rty_i[s];
            rsp_dat = wbs_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (owned) begin
         wbs_cyc_o[dec]   = own_cyc;
         wbs_stb_o[dec]   = own_stb;
         wbm_ack_o[gnt_q] = rsp_ack;
         wbm_err_o[gnt_q] = rsp_err | tmo;
         wbm_rty_o[gnt_q] = rsp_rty;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      found   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|wbm_cyc_i) begin
               // Scan offsets 1..N from the last owner so the previous winner is checked last.
               for (int unsigned off = 1; off <= MASTER_COUNT; off++) begin
                  for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
                     if (!found && wbm_cyc_i[k] &&
                         ((32'(last_q) + off) % MASTER_COUNT) == k) begin
                        found  = 1'b1;
                        gnt_d  = GW'(k);
                        last_d = GW'(k);
                     end
                  end
               end
               state_d = OWNED;
            end
         end
         OWNED: begin
            if (!own_cyc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= GW'(MASTER_COUNT - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

`ifdef WB_CROSSBAR_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rsp_any;

   assign rsp_any = rsp_ack | rsp_err | rsp_rty;

   always_comb begin
      tmo   = owned && own_stb && !rsp_any && (cnt_q == CW'(TIMEOUT));
      cnt_d = cnt_q + CW'(1);
      if (!owned || !own_stb || rsp_any || tmo) cnt_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

endmodule
